// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM round-robin arbiter.
package sram_arb_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/sram_rr_arbiter_pick.sv
// Combinational round-robin pick: first requesting index at or after ptr,
// returned both one-hot and as an index.
module rr_priority_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NREQ requesters,
// with bounded burst lock. Optional counters under SRAM_ARB_PERF_CNT_EN.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BURST_MAX = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned BW = $clog2(BURST_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  sram_ren,
  output logic                  sram_wen,
  output logic [AW-1:0]         sram_addr,
  output logic [WIDTH-1:0]      sram_d,
  input  logic [WIDTH-1:0]      sram_q
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [NREQ*PERF_W-1:0] perf_gnt,
  output logic [NREQ*PERF_W-1:0] perf_wait_max
`endif
);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt, owner, owner_nxt;
  logic [BW-1:0]   beat_cnt, beat_nxt;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [IW-1:0]   win;
  logic            win_any;
  logic [AW-1:0]   addr_hold;
  logic [WIDTH-1:0] d_hold;
  logic            rd_pend;
  logic [IW-1:0]   rd_owner;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (32'(i) == NREQ - 1) ? '0 : IW'(i + 1'b1);
  endfunction

  rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // Grants are suppressed while reset is held so nothing reaches the SRAM.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    gnt       = '0;
    win       = pick_idx;
    win_any   = 1'b0;
    if (rst) begin
      unique case (state)
        ST_ARB: begin
          if (pick_found) begin
            gnt     = pick_gnt;
            win_any = 1'b1;
            if (req_lock[pick_idx] && BURST_MAX > 1) begin
              state_nxt = ST_BURST;
              owner_nxt = pick_idx;
              beat_nxt  = BW'(1);
            end else begin
              ptr_nxt = inc_wrap(pick_idx);
            end
          end
        end
        ST_BURST: begin
          win = owner;
          if (req[owner]) begin
            gnt[owner] = 1'b1;
            win_any    = 1'b1;
            beat_nxt   = beat_cnt + BW'(1);
          end
          if (!req[owner] || !req_lock[owner] || (32'(beat_cnt) + 32'd1 >= BURST_MAX)) begin
            state_nxt = ST_ARB;
            ptr_nxt   = inc_wrap(owner);
            beat_nxt  = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    sram_ren  = win_any && (req_we[win] == OP_RD);
    sram_wen  = win_any && (req_we[win] == OP_WR);
    sram_addr = win_any ? req_addr[32'(win)*AW +: AW] : addr_hold;
    sram_d    = win_any ? req_wdata[32'(win)*WIDTH +: WIDTH] : d_hold;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ARB;
      ptr       <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      addr_hold <= '0;
      d_hold    <= '0;
      rd_pend   <= 1'b0;
      rd_owner  <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
      if (win_any) begin
        addr_hold <= sram_addr;
        d_hold    <= sram_d;
      end
      rd_pend  <= sram_ren;
      rd_owner <= win;
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (rd_pend) begin
      rvalid[rd_owner] = 1'b1;
      rdata            = sram_q;
    end
  end

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [NREQ*PERF_W-1:0] wait_cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_gnt      <= '0;
      perf_wait_max <= '0;
      wait_cur      <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[i] && (perf_gnt[i*PERF_W +: PERF_W] != '1))
          perf_gnt[i*PERF_W +: PERF_W] <= perf_gnt[i*PERF_W +: PERF_W] + 1'b1;
        if (req[i] && !gnt[i]) begin
          if (wait_cur[i*PERF_W +: PERF_W] != '1) begin
            wait_cur[i*PERF_W +: PERF_W] <= wait_cur[i*PERF_W +: PERF_W] + 1'b1;
            if (wait_cur[i*PERF_W +: PERF_W] >= perf_wait_max[i*PERF_W +: PERF_W])
              perf_wait_max[i*PERF_W +: PERF_W] <= wait_cur[i*PERF_W +: PERF_W] + 1'b1;
          end
        end else begin
          wait_cur[i*PERF_W +: PERF_W] <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed and randomized self-checking bench for sram_rr_arbiter.
module tb_sram_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int BM    = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0, req_we = '0, req_lock = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
  logic [NREQ-1:0]       gnt, rvalid;
  logic [WIDTH-1:0]      rdata, sram_d, sram_q;
  logic                  sram_ren, sram_wen;
  logic [AW-1:0]         sram_addr;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [NREQ*32-1:0]    perf_gnt, perf_wait_max;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q)
`ifdef SRAM_ARB_PERF_CNT_EN
    , .perf_gnt(perf_gnt), .perf_wait_max(perf_wait_max)
`endif
  );

  // Behavioural single-port SRAM: 1-cycle read, dummy 189 when not reading.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_d;
    sram_q <= sram_ren ? mem[sram_addr] : 32'd189;
  end

  task automatic clear_in();
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_op(input int r, input logic we, input logic lock,
                        input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req[r] = 1'b1; req_we[r] = we; req_lock[r] = lock;
    req_addr[r*AW +: AW] = a; req_wdata[r*WIDTH +: WIDTH] = d;
  endtask

  task automatic test_reset();
    logic [NREQ-1:0] exp_rot [5];
    exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(negedge clk); rst = 1'b1; clear_in();
    @(negedge clk); clear_in(); set_op(1, 1'b0, 1'b1, 5'd3, '0);
    @(posedge clk); #2; rst = 1'b0; #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    checks++; if ({sram_ren, sram_wen} !== 2'b00) begin errors++; $display("FAIL rst_renwen: got %b want 00", {sram_ren, sram_wen}); end
    @(negedge clk); clear_in();
    for (int r = 0; r < NREQ; r++) set_op(r, 1'b0, 1'b0, AW'(r), '0);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_held_gnt: got %b want 0000", gnt); end
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      checks++; if (gnt !== exp_rot[k]) begin errors++; $display("FAIL rst_rot%0d: got %b want %b", k, gnt, exp_rot[k]); end
      if (k == 1) begin
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL rst_first_rvalid: got %b want 0001", rvalid); end
      end
    end
    @(negedge clk); clear_in();
  endtask

  task automatic test_write_read();
    @(negedge clk); clear_in(); set_op(0, 1'b1, 1'b0, 5'd5, 32'hDEAD); #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
    checks++; if ({sram_ren, sram_wen} !== 2'b01) begin errors++; $display("FAIL wr_renwen: got %b want 01", {sram_ren, sram_wen}); end
    checks++; if (sram_addr !== 5'd5 || sram_d !== 32'hDEAD) begin errors++; $display("FAIL wr_addr_d: got %0d/%h want 5/dead", sram_addr, sram_d); end
    @(negedge clk); clear_in(); set_op(1, 1'b0, 1'b0, 5'd5, '0); #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rd_gnt: got %b want 0010", gnt); end
    checks++; if ({sram_ren, sram_wen} !== 2'b10) begin errors++; $display("FAIL rd_renwen: got %b want 10", {sram_ren, sram_wen}); end
    @(negedge clk); clear_in(); #1;
    checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL raw_rvalid: got %b want 0010", rvalid); end
    checks++; if (rdata !== 32'hDEAD) begin errors++; $display("FAIL raw_rdata: got %h want dead", rdata); end
    checks++; if (gnt !== 4'b0000 || {sram_ren, sram_wen} !== 2'b00) begin errors++; $display("FAIL idle_gnt: got %b/%b want 0000/00", gnt, {sram_ren, sram_wen}); end
    checks++; if (sram_addr !== 5'd5) begin errors++; $display("FAIL idle_addr_hold: got %0d want 5", sram_addr); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 4'b0000 || rdata !== 32'd0) begin errors++; $display("FAIL idle_rdata: got %b/%h want 0000/0", rvalid, rdata); end
  endtask

  task automatic test_burst();
    logic [NREQ-1:0] exp_b [6];
    exp_b = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    @(negedge clk); clear_in();
    for (int r = 0; r < NREQ; r++) set_op(r, 1'b0, (r == 2), AW'(8 + r), '0);
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      checks++; if (gnt !== exp_b[k]) begin errors++; $display("FAIL burst_gnt%0d: got %b want %b", k, gnt, exp_b[k]); end
    end
  endtask

  task automatic test_burst_release();
    @(negedge clk); clear_in();
    for (int r = 0; r < NREQ; r++) set_op(r, 1'b0, (r == 1), AW'(r), '0);
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rel_enter: got %b want 0010", gnt); end
    @(negedge clk); req_lock[1] = 1'b0; #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rel_unlock: got %b want 0010", gnt); end
    @(negedge clk); req_lock[2] = 1'b1; #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rel_next: got %b want 0100", gnt); end
    @(negedge clk); req[2] = 1'b0; #1;
    checks++; if (gnt !== 4'b0000 || sram_ren !== 1'b0) begin errors++; $display("FAIL rel_drop: got %b ren %b want 0000 0", gnt, sram_ren); end
    @(negedge clk); #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rel_after_drop: got %b want 1000", gnt); end
    @(negedge clk); clear_in();
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) begin
      @(negedge clk); clear_in(); set_op(3, 1'b1, 1'b0, AW'(a), 32'h1000 + a); #1;
      checks++; if (gnt !== 4'b1000 || sram_wen !== 1'b1) begin errors++; $display("FAIL b2b_wr%0d: got %b wen %b want 1000 1", a, gnt, sram_wen); end
    end
    for (int a = 0; a <= 8; a++) begin
      @(negedge clk); clear_in();
      if (a < 8) set_op(3, 1'b0, 1'b0, AW'(a), '0);
      #1;
      if (a < 8) begin
        checks++; if (gnt !== 4'b1000 || sram_ren !== 1'b1) begin errors++; $display("FAIL b2b_rdgnt%0d: got %b ren %b want 1000 1", a, gnt, sram_ren); end
      end
      if (a > 0) begin
        checks++;
        if (rvalid !== 4'b1000 || rdata !== 32'h1000 + a - 1) begin
          errors++; $display("FAIL b2b_rdata%0d: got %b/%h want 1000/%h", a - 1, rvalid, rdata, 32'h1000 + a - 1);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [WIDTH-1:0] shadow [DEPTH];
    logic             exp_pend = 1'b0;
    int               exp_owner = 0;
    logic [WIDTH-1:0] exp_data = '0;
    int               waitc [NREQ];
    logic [NREQ-1:0]  ev;
    int               w, worst;
    logic [AW-1:0]    a;
    for (int r = 0; r < NREQ; r++) waitc[r] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); clear_in();
      shadow[i] = WIDTH'($urandom);
      set_op(0, 1'b1, 1'b0, AW'(i), shadow[i]);
    end
    @(negedge clk); clear_in();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ev = '0;
      if (exp_pend) ev[exp_owner] = 1'b1;
      checks++;
      if (rvalid !== ev || rdata !== (exp_pend ? exp_data : 32'd0)) begin
        errors++; $display("FAIL rnd_read c%0d: got %b/%h want %b/%h", c, rvalid, rdata, ev, exp_pend ? exp_data : 32'd0);
      end
      clear_in();
      for (int r = 0; r < NREQ; r++)
        if ($urandom_range(3) != 0)
          set_op(r, 1'($urandom_range(1)), ($urandom_range(3) == 0), AW'($urandom_range(DEPTH - 1)), WIDTH'($urandom));
      #1;
      checks++;
      if (!$onehot0(gnt) || (gnt & ~req) != '0) begin errors++; $display("FAIL rnd_gnt_legal c%0d: got %b req %b", c, gnt, req); end
      checks++;
      if (sram_ren && sram_wen) begin errors++; $display("FAIL rnd_renwen c%0d: got 11 want not both", c); end
      w = -1;
      for (int r = 0; r < NREQ; r++) if (gnt[r]) w = r;
      exp_pend = 1'b0;
      if (w >= 0) begin
        a = req_addr[w*AW +: AW];
        checks++;
        if (sram_ren !== !req_we[w] || sram_wen !== req_we[w] || sram_addr !== a ||
            (req_we[w] && sram_d !== req_wdata[w*WIDTH +: WIDTH])) begin
          errors++; $display("FAIL rnd_mux c%0d: got ren%b wen%b a%0d d%h for req%0d", c, sram_ren, sram_wen, sram_addr, sram_d, w);
        end
        if (req_we[w]) shadow[a] = req_wdata[w*WIDTH +: WIDTH];
        else begin exp_pend = 1'b1; exp_owner = w; exp_data = shadow[a]; end
      end else begin
        checks++;
        if (sram_ren || sram_wen) begin errors++; $display("FAIL rnd_idle c%0d: got ren%b wen%b want 00", c, sram_ren, sram_wen); end
      end
      worst = 0;
      for (int r = 0; r < NREQ; r++) begin
        waitc[r] = (req[r] && !gnt[r]) ? waitc[r] + 1 : 0;
        if (waitc[r] > worst) worst = waitc[r];
      end
      checks++;
      if (worst > (NREQ - 1) * BM) begin errors++; $display("FAIL rnd_starve c%0d: got wait %0d want <= %0d", c, worst, (NREQ - 1) * BM); end
    end
    @(negedge clk); clear_in();
  endtask

`ifdef SRAM_ARB_PERF_CNT_EN
  task automatic test_perf();
    logic [NREQ-1:0] exp_p [6];
    exp_p = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    @(negedge clk); clear_in(); rst = 1'b0; #1;
    checks++; if (perf_gnt !== '0 || perf_wait_max !== '0) begin errors++; $display("FAIL perf_reset: got %h/%h want 0/0", perf_gnt, perf_wait_max); end
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 0) set_op(1, 1'b0, 1'b1, 5'd0, '0);
      if (k == 1) set_op(0, 1'b0, 1'b0, 5'd1, '0);
      if (k == 2) req_lock[1] = 1'b0;
      if (k == 3) req[1] = 1'b0;
      #1;
      checks++; if (gnt !== exp_p[k]) begin errors++; $display("FAIL perf_gnt_seq%0d: got %b want %b", k, gnt, exp_p[k]); end
    end
    @(negedge clk); clear_in(); #1;
    checks++; if (perf_gnt[0 +: 32] !== 32'd3) begin errors++; $display("FAIL perf_gnt0: got %0d want 3", perf_gnt[0 +: 32]); end
    checks++; if (perf_wait_max[0 +: 32] !== 32'd2) begin errors++; $display("FAIL perf_wait0: got %0d want 2", perf_wait_max[0 +: 32]); end
    checks++; if (perf_gnt[32 +: 32] !== 32'd3 || perf_wait_max[32 +: 32] !== 32'd0) begin
      errors++; $display("FAIL perf_req1: got %0d/%0d want 3/0", perf_gnt[32 +: 32], perf_wait_max[32 +: 32]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_burst_release();
    test_back_to_back();
    test_random(3000);
`ifdef SRAM_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
